// File: rtl/vga_timing_out.sv
// Raster timing generator with a one-pixel registered output stage for the overlay RGB bus.
// Output latency is one pixel period; no backpressure, the DAC consumes one pixel on every pix_ce edge.
module vga_timing_out #(
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter logic        SYNC_POL = 1'b0,
   parameter int          CLK_DIV  = 1,
   parameter logic [23:0] BG_RGB   = 24'h000000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        pix_ce,
   input  logic [7:0]  bus_r,
   input  logic [7:0]  bus_g,
   input  logic [7:0]  bus_b,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_de,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [1:0] DIV_LAST   = 2'(CLK_DIV - 1);

   logic [1:0]  div_cnt_q, div_cnt_d;
   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic [23:0] rgb_q, rgb_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        de_q, de_d;
   logic        line_start_q, line_start_d;
   logic        frame_start_q, frame_start_d;
   logic [15:0] frame_count_q, frame_count_d;

   logic        h_wrap, v_wrap, in_hs, in_vs, de_next;
   logic [23:0] bus_rgb;

   assign pix_ce = (div_cnt_q == DIV_LAST);

   always_comb begin
      h_wrap        = (h_cnt_q == H_LAST);
      v_wrap        = (v_cnt_q == V_LAST);
      in_hs         = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
      in_vs         = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
      de_next       = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
      bus_rgb       = {bus_r, bus_g, bus_b};

      div_cnt_d     = pix_ce ? 2'd0 : div_cnt_q + 2'd1;
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      rgb_d         = rgb_q;
      hs_d          = hs_q;
      vs_d          = vs_q;
      de_d          = de_q;
      line_start_d  = pix_ce && h_wrap;
      frame_start_d = pix_ce && h_wrap && v_wrap;
      frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;

      if (pix_ce) begin
         h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
         if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
         end
         // All three come from the same counter snapshot, so geometry and syncs stay aligned.
         de_d = de_next;
         hs_d = in_hs ? SYNC_POL : ~SYNC_POL;
         vs_d = in_vs ? SYNC_POL : ~SYNC_POL;
         if (!de_next) begin
            rgb_d = 24'h000000;
         end else if (bus_rgb == 24'h000000) begin
            rgb_d = BG_RGB;
         end else begin
            rgb_d = bus_rgb;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q     <= 2'd0;
         h_cnt_q       <= 10'd0;
         v_cnt_q       <= 10'd0;
         rgb_q         <= 24'h000000;
         hs_q          <= ~SYNC_POL;
         vs_q          <= ~SYNC_POL;
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         rgb_q         <= rgb_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         de_q          <= de_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign pix_x       = h_cnt_q;
   assign pix_y       = v_cnt_q;
   assign vga_r       = rgb_q[23:16];
   assign vga_g       = rgb_q[15:8];
   assign vga_b       = rgb_q[7:0];
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_de      = de_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out on a shrunken raster with CLK_DIV=2 and a non-zero background,
// random overlay bus, mid-sync reset and a frame counter wrap.
module tb_vga_timing_out;

   localparam int          HA  = 16, HFP = 2, HSW = 3, HBP = 4;
   localparam int          VA  = 6,  VFP = 1, VSW = 2, VBP = 2;
   localparam int          CD  = 2;
   localparam logic        SP  = 1'b0;
   localparam logic [23:0] BG  = 24'h102030;
   localparam int          HT  = HA + HFP + HSW + HBP;
   localparam int          VT  = VA + VFP + VSW + VBP;

   typedef struct packed {
      logic [23:0] rgb;
      logic        hs;
      logic        vs;
      logic        de;
   } pix_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  bus_r = 8'h00, bus_g = 8'h00, bus_b = 8'h00;
   logic [9:0]  pix_x, pix_y;
   logic        pix_ce;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_de;
   logic        line_start, frame_start;
   logic [15:0] frame_count;

   pix_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   vga_timing_out #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .SYNC_POL(SP), .CLK_DIV(CD), .BG_RGB(BG)
   ) dut (
      .clk(clk), .rst(rst),
      .pix_x(pix_x), .pix_y(pix_y), .pix_ce(pix_ce),
      .bus_r(bus_r), .bus_g(bus_g), .bus_b(bus_b),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
      .line_start(line_start), .frame_start(frame_start),
      .frame_count(frame_count)
   );

   // What the DAC should see for the pixel at raster position (h, v) with bus value b.
   function automatic pix_t ref_pixel(input int h, input int v, input logic [23:0] b);
      pix_t p;
      p.de  = (h < HA) && (v < VA);
      p.rgb = !p.de ? 24'h000000 : ((b == 24'h000000) ? BG : b);
      p.hs  = (h >= HA + HFP && h < HA + HFP + HSW) ? SP : ~SP;
      p.vs  = (v >= VA + VFP && v < VA + VFP + VSW) ? SP : ~SP;
      return p;
   endfunction

   // Monitor: pops one expectation after every non-reset pix_ce edge.
   initial begin
      bit   up_ce  = 1'b0;
      bit   up_rst = 1'b1;
      pix_t e;
      forever begin
         @(negedge clk);
         #1;
         if (up_ce && !up_rst) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL scoreboard_underflow: output strobe seen with no expected pixel at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de} !== e) begin
                  fails++;
                  $display("FAIL pixel at %0t: got rgb=%h hs=%b vs=%b de=%b, want rgb=%h hs=%b vs=%b de=%b",
                           $time, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_de,
                           e.rgb, e.hs, e.vs, e.de);
               end
            end
         end
         up_ce  = pix_ce;
         up_rst = rst;
      end
   end

   // Stimulus and raster model: position is derived from clocks elapsed since reset.
   initial begin
      int          k = 0;
      int          cyc = 0;
      int          t, h, v;
      bit          ls_e, fs_e, ce_e;
      bit          did_rst = 1'b0, did_force = 1'b0, forcing = 1'b0, done = 1'b0;
      logic [15:0] fc_exp = 16'd0;
      logic [23:0] bus;

      while (!done) begin
         @(negedge clk);
         cyc++;
         if (rst) k = 0;
         else     k++;
         if (forcing) begin
            release dut.frame_count_q;
            forcing = 1'b0;
            fc_exp  = 16'hFFFF;
         end
         t    = k / CD;
         h    = t % HT;
         v    = (t / HT) % VT;
         ce_e = ((k + 1) % CD) == 0;

         tests++;
         if (rst) begin
            fc_exp = 16'd0;
            if (pix_x !== 10'd0 || pix_y !== 10'd0 || {vga_r, vga_g, vga_b} !== 24'h0 ||
                vga_de !== 1'b0 || vga_hs !== ~SP || vga_vs !== ~SP ||
                line_start !== 1'b0 || frame_start !== 1'b0 || frame_count !== 16'd0) begin
               fails++;
               $display("FAIL reset_state at %0t: got x=%0d y=%0d rgb=%h de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want all zero with hs=vs=%b",
                        $time, pix_x, pix_y, {vga_r, vga_g, vga_b}, vga_de, vga_hs, vga_vs,
                        line_start, frame_start, frame_count, ~SP);
            end
         end else begin
            ls_e = (k > 0) && (k % CD == 0) && (t % HT == 0);
            fs_e = ls_e && ((t / HT) % VT == 0);
            if (fs_e) fc_exp = fc_exp + 16'd1;
            if (pix_x !== 10'(h) || pix_y !== 10'(v) || pix_ce !== ce_e ||
                line_start !== ls_e || frame_start !== fs_e || frame_count !== fc_exp) begin
               fails++;
               $display("FAIL raster at %0t: got x=%0d y=%0d ce=%b ls=%b fs=%b fc=%0d, want x=%0d y=%0d ce=%b ls=%b fs=%b fc=%0d",
                        $time, pix_x, pix_y, pix_ce, line_start, frame_start, frame_count,
                        h, v, ce_e, ls_e, fs_e, fc_exp);
            end
         end

         // Reset once in the middle of an hsync pulse that also sits inside vsync.
         if (cyc < 4) begin
            rst = 1'b1;
         end else if (!did_rst && !rst && fc_exp == 16'd3 && h == HA + HFP + 1 && v == VA + VFP) begin
            rst     = 1'b1;
            did_rst = 1'b1;
         end else begin
            rst = 1'b0;
         end

         if (did_rst && !did_force && !rst && fc_exp == 16'd1 && h == 5) begin
            force dut.frame_count_q = 16'hFFFF;
            forcing   = 1'b1;
            did_force = 1'b1;
         end

         case ($urandom_range(0, 3))
            0:       bus = 24'h000000;
            1:       bus = 24'hFFFFFF;
            default: bus = 24'($urandom);
         endcase
         {bus_r, bus_g, bus_b} = bus;
         if (!rst && ce_e) exp_q.push_back(ref_pixel(h, v, bus));

         done = did_force && !forcing && fc_exp == 16'd1;
         if (cyc > 20000) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d cycles, want frame counter wrap sequence to finish", cyc);
            done = 1'b1;
         end
      end

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #2;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d pixels left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_timing_out.md
Name: vga_timing_out

Overview:
- Raster engine for the scope display.
- Sits upstream of the geometry primitives (hline, vline, graticule): drives the pix_x/pix_y counters they compare against.
- Sits downstream of them: samples the shared RGB overlay bus they write, substitutes the background colour where no primitive drives, and registers the result with sync pulses aligned.
- Default timing is 640x480 @ 60 Hz at a 25 MHz pixel rate.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- CLK_DIV, 1, clk cycles per pixel (1..4; 2 for a 50 MHz clk)
- BG_RGB, 24'h000000, background colour {r,g,b} used where the bus reads transparent

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_x  out  10  current horizontal counter, 0..H_TOTAL-1
- pix_y  out  10  current vertical counter, 0..V_TOTAL-1
- pix_ce  out  1  one-clk strobe; pix_x/pix_y advance on the clk edge following it
- bus_r  in  8  overlay bus red (pulled down at top level)
- bus_g  in  8  overlay bus green (pulled down at top level)
- bus_b  in  8  overlay bus blue (pulled down at top level)
- vga_r  out  8  registered red to DAC
- vga_g  out  8  registered green to DAC
- vga_b  out  8  registered blue to DAC
- vga_hs  out  1  registered hsync
- vga_vs  out  1  registered vsync
- vga_de  out  1  registered display enable (active video)
- line_start  out  1  one-clk pulse when pix_x wraps to 0
- frame_start  out  1  one-clk pulse when pix_x and pix_y both wrap to 0
- frame_count  out  16  frames completed since reset, wraps at 65535 -> 0

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - pix_ce = (div_cnt == CLK_DIV-1).
  - With CLK_DIV = 1, pix_ce is constantly 1 after reset.
- Counters update only on clk edges where pix_ce = 1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0.
  - pix_x = h_cnt and pix_y = v_cnt, driven directly from the counter registers (no decode delay).
- Horizontal phases by h_cnt:
  - ACTIVE [0, H_ACTIVE-1]
  - FP [H_ACTIVE, H_ACTIVE+H_FP-1]
  - SYNC [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751
  - BP for the remainder
- Vertical phases by v_cnt follow the same scheme; vsync asserts on lines 490..491.
- Output stage, updated on pix_ce edges only:
  - One pixel of latency. Bus, sync and DE all come from the same pix_x/pix_y sampled in the previous pixel period, so the combinational geometry output lines up with the syncs.
  - de_next = h ACTIVE and v ACTIVE.
  - If de_next = 0: vga_r/g/b <= 0.
  - Else if {bus_r,bus_g,bus_b} == 24'h000000 (transparent, pulled down): vga_rgb <= BG_RGB.
  - Else: vga_rgb <= bus value.
  - vga_hs <= SYNC_POL when h is in SYNC, else ~SYNC_POL; vga_vs likewise for v.
- Pulses:
  - line_start and frame_start are high for exactly one clk, on the clk after the edge at which the counter wrapped.
  - frame_count increments on that same edge as frame_start.
- Reset, when rst = 1 on a clk edge:
  - div_cnt, h_cnt, v_cnt = 0; frame_count = 0.
  - vga_r/g/b = 0; vga_de = 0; line_start = frame_start = 0.
  - vga_hs = vga_vs = ~SYNC_POL.
  - Reset mid-line or mid-sync abandons the frame immediately. The first pix_ce after rst deasserts advances h_cnt from 0 to 1, and no frame_start is issued for that partial start.
- Simultaneous events: at h = H_TOTAL-1 and v = V_TOTAL-1 on a pix_ce edge, both counters wrap on the same edge, and line_start and frame_start pulse together.

Test Plan:
- Default params, CLK_DIV=1, release rst -> hsync low exactly for h_cnt 656..751 (96 clk), period 800 clk; vsync low 2 lines (1600 clk), period 420000 clk.
- Drive bus=24'h00FF00 only while pix_x==10 && pix_y==5 -> vga_g=8'hFF with vga_de=1 exactly one pixel later, all other active pixels = BG_RGB.
- BG_RGB=24'h102030, bus held 0 -> every active pixel 8'h10/20/30; pixel with h_cnt=640 (blanking) outputs 0 while bus forced 24'hFFFFFF.
- CLK_DIV=2 -> pix_ce toggles every other clk, line period 1600 clk, hsync width 192 clk.
- Run 3 frames -> frame_start pulses 3 times, each coincident with line_start, frame_count=3; preload frame_count to 65535 via force -> wraps to 0.
- Assert rst for 1 clk at h=700 (mid-hsync) -> next clk vga_hs=1 (SYNC_POL=0), pix_x=0, no frame_start until first full wrap.
